// File: rtl/lte_ul_pkg.sv
// Shared constants for the LTE uplink antenna reorder block.
// Default geometry, posinfo field width and error-counter limit.
package lte_ul_pkg;
  localparam int NUM_ANT_DEF = 8;
  localparam int SAMP_W_DEF = 16;
  localparam int POS_FLD_W = 4;
  localparam logic [15:0] ERR_SAT = 16'hFFFF;
endpackage

// File: rtl/lte_ul_ant_reorder_if.sv
// Sample-stream bus of the antenna reorder block.
// master: stream source/sink side; slave: reorder block side.
interface lte_ul_ant_reorder_if
  import lte_ul_pkg::*;
#(
  parameter int SAMP_W = SAMP_W_DEF
);
  logic                i_fram_hd;
  logic [SAMP_W-1:0]   i_data;
  logic                i_data_valid;
  logic                o_fram_hd;
  logic                o_ant_sel;
  logic [2*SAMP_W-1:0] o_data;
  logic                o_data_valid;
  logic                o_err_hd;

  modport master (
    output i_fram_hd, i_data, i_data_valid,
    input  o_fram_hd, o_ant_sel, o_data,
    input  o_data_valid, o_err_hd
  );

  modport slave (
    input  i_fram_hd, i_data, i_data_valid,
    output o_fram_hd, o_ant_sel, o_data,
    output o_data_valid, o_err_hd
  );
endinterface

// File: rtl/lte_ul_reorder_dpram.sv
// Two-bank sample buffer: SAMP_W write port, {Q,I} pair read port.
// Ports: clk, we/waddr/wdata (sample), raddr (bank,ant) -> rdata (1 cycle).
module lte_ul_reorder_dpram #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW:0]     waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [AW-1:0]   raddr,
  output logic [2*DW-1:0] rdata_q
);
  logic [DW-1:0] mem_i [2**AW];
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] i_d;
  logic [DW-1:0] q_d;
  logic          hit;

  // The last Q sample of a group is written in the same cycle the
  // reader may fetch it, so writes forward into the read.
  always_comb begin
    hit = we && (waddr[AW:1] == raddr);
    i_d = mem_i[raddr];
    q_d = mem_q[raddr];
    if (hit && !waddr[0]) i_d = wdata;
    if (hit && waddr[0])  q_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (we && !waddr[0]) mem_i[waddr[AW:1]] <= wdata;
    if (we && waddr[0])  mem_q[waddr[AW:1]] <= wdata;
    rdata_q <= {q_d, i_d};
  end
endmodule

// File: rtl/lte_ul_ant_reorder.sv
// Uplink antenna reorder: buffers one group of I/Q samples per antenna
// and replays it in posinfo slot order with per-slot masking.
// Ports: clk_491p52, rst_491p52 (sync, high), i_ant_posinfo, i_ant_mask,
// bus (stream in/out); o_err_cnt only with LTE_UL_REORDER_ERRCNT_EN.
module lte_ul_ant_reorder
  import lte_ul_pkg::*;
#(
  parameter int NUM_ANT = NUM_ANT_DEF,
  parameter int SAMP_W  = SAMP_W_DEF,
  parameter int POS_W   = $clog2(NUM_ANT)
) (
  input  logic                       clk_491p52,
  input  logic                       rst_491p52,
  input  logic [POS_FLD_W*NUM_ANT-1:0] i_ant_posinfo,
  input  logic [NUM_ANT-1:0]         i_ant_mask,
  lte_ul_ant_reorder_if.slave        bus
`ifdef LTE_UL_REORDER_ERRCNT_EN
  ,
  output logic [15:0]                o_err_cnt
`endif
);
  localparam int WC_W = POS_W + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(2*NUM_ANT-1);
  localparam logic [POS_W-1:0] SL_LAST = POS_W'(NUM_ANT-1);
  localparam int PI_W = POS_FLD_W*NUM_ANT;

  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic              rd_act_q, rd_act_d;
  logic [POS_W-1:0]  slot_q, slot_d;
  logic [PI_W-1:0]   pos_sh_q, pos_sh_d;
  logic [NUM_ANT-1:0] mask_sh_q, mask_sh_d;
  logic              fhd_pend_q, fhd_pend_d;
  logic              v1_q, v1_d;
  logic              sel1_q, sel1_d;
  logic              zero1_q, zero1_d;
  logic              fhd1_q, fhd1_d;
  logic              o_valid_q, o_valid_d;
  logic              o_sel_q, o_sel_d;
  logic              o_fhd_q, o_fhd_d;
  logic              o_err_q, o_err_d;
  logic [2*SAMP_W-1:0] o_data_q, o_data_d;

  logic              wr, fhd, start;
  logic [WC_W:0]     waddr;
  logic [POS_W:0]    raddr;
  logic [PI_W-1:0]   rd_pos;
  logic [NUM_ANT-1:0] rd_mask;
  logic [POS_W-1:0]  rd_slot;
  logic [POS_FLD_W-1:0] fld;
  logic              rd_zero;
  logic [2*SAMP_W-1:0] ram_q;

  assign wr    = bus.i_data_valid;
  assign fhd   = bus.i_fram_hd;
  assign start = wr && !fhd && (wcnt_q == WC_LAST);

  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    if (fhd) begin
      wcnt_d = wr ? WC_W'(1) : '0;
    end else if (wr) begin
      wcnt_d = wcnt_q + WC_W'(1);
      if (start) wbank_d = ~wbank_q;
    end
    waddr = {wbank_q, fhd ? {WC_W{1'b0}} : wcnt_q};
  end

  // Slot 0 is fetched in the cycle the group completes, straight from
  // the live config; later slots use the latched shadow copy.
  always_comb begin
    rd_pos  = start ? i_ant_posinfo : pos_sh_q;
    rd_mask = start ? i_ant_mask : mask_sh_q;
    rd_slot = start ? '0 : slot_q;
    fld     = rd_pos[{rd_slot, 2'b00} +: POS_FLD_W];
    rd_zero = rd_mask[rd_slot] ||
              ((fld >> POS_W) != '0);
    raddr   = {start ? wbank_q : rbank_q,
               fld[POS_W-1:0]};
  end

  always_comb begin
    rd_act_d   = rd_act_q;
    slot_d     = slot_q;
    rbank_d    = rbank_q;
    pos_sh_d   = pos_sh_q;
    mask_sh_d  = mask_sh_q;
    fhd_pend_d = fhd_pend_q;
    if (fhd) fhd_pend_d = 1'b1;
    if (start) begin
      rd_act_d   = 1'b1;
      slot_d     = POS_W'(1);
      rbank_d    = wbank_q;
      pos_sh_d   = i_ant_posinfo;
      mask_sh_d  = i_ant_mask;
      fhd_pend_d = 1'b0;
    end else if (rd_act_q) begin
      slot_d = slot_q + POS_W'(1);
      if (slot_q == SL_LAST) rd_act_d = 1'b0;
    end
  end

  always_comb begin
    v1_d      = start || rd_act_q;
    sel1_d    = start;
    zero1_d   = rd_zero;
    fhd1_d    = start && fhd_pend_q;
    o_valid_d = v1_q;
    o_sel_d   = v1_q && sel1_q;
    o_fhd_d   = v1_q && fhd1_q;
    o_data_d  = (v1_q && !zero1_q) ? ram_q : '0;
    o_err_d   = fhd && (wcnt_q != '0);
  end

  always_ff @(posedge clk_491p52) begin
    if (rst_491p52) begin
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      rd_act_q   <= 1'b0;
      slot_q     <= '0;
      pos_sh_q   <= '0;
      mask_sh_q  <= '0;
      fhd_pend_q <= 1'b0;
      v1_q       <= 1'b0;
      sel1_q     <= 1'b0;
      zero1_q    <= 1'b0;
      fhd1_q     <= 1'b0;
      o_valid_q  <= 1'b0;
      o_sel_q    <= 1'b0;
      o_fhd_q    <= 1'b0;
      o_err_q    <= 1'b0;
      o_data_q   <= '0;
    end else begin
      wcnt_q     <= wcnt_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      rd_act_q   <= rd_act_d;
      slot_q     <= slot_d;
      pos_sh_q   <= pos_sh_d;
      mask_sh_q  <= mask_sh_d;
      fhd_pend_q <= fhd_pend_d;
      v1_q       <= v1_d;
      sel1_q     <= sel1_d;
      zero1_q    <= zero1_d;
      fhd1_q     <= fhd1_d;
      o_valid_q  <= o_valid_d;
      o_sel_q    <= o_sel_d;
      o_fhd_q    <= o_fhd_d;
      o_err_q    <= o_err_d;
      o_data_q   <= o_data_d;
    end
  end

  lte_ul_reorder_dpram #(
    .AW (POS_W + 1),
    .DW (SAMP_W)
  ) u_buf (
    .clk     (clk_491p52),
    .we      (wr),
    .waddr   (waddr),
    .wdata   (bus.i_data),
    .raddr   (raddr),
    .rdata_q (ram_q)
  );

  assign bus.o_data_valid = o_valid_q;
  assign bus.o_ant_sel    = o_sel_q;
  assign bus.o_fram_hd    = o_fhd_q;
  assign bus.o_err_hd     = o_err_q;
  assign bus.o_data       = o_data_q;

`ifdef LTE_UL_REORDER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (o_err_d && err_cnt_q != ERR_SAT)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_491p52) begin
    if (rst_491p52) err_cnt_q <= '0;
    else            err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt = err_cnt_q;
`endif
endmodule

// File: doc/lte_ul_ant_reorder.md
LTE_UL_ANT_REORDER -- requirements
Module: lte_ul_ant_reorder

Interface
REQ-001 Parameter NUM_ANT, default 8, antenna count per group; power of 2, range 2..16.
REQ-002 Parameter SAMP_W, default 16, width of one I or Q input sample.
REQ-003 Parameter POS_W, default clog2(NUM_ANT), derived; not overridden.
REQ-004 Port clk_491p52  in  1  the only clock; one clock, all logic on rising edge.
REQ-005 Port rst_491p52  in  1  reset, synchronous, active-high.
REQ-006 Port i_ant_posinfo  in  4*NUM_ANT  4-bit source-antenna field per output slot k at bits [4k+3:4k].
REQ-007 Port i_ant_mask  in  NUM_ANT  bit k high forces slot k output to zero.
REQ-008 Port i_fram_hd  in  1  frame-head pulse, marks first sample of a frame.
REQ-009 Port i_data  in  SAMP_W  input sample stream, order ant0 I, ant0 Q, ant1 I, ... per group.
REQ-010 Port i_data_valid  in  1  qualifies i_data.
REQ-011 Port o_fram_hd  out  1  pulse coincident with first output word of a frame.
REQ-012 Port o_ant_sel  out  1  high on slot-0 word of each output group.
REQ-013 Port o_data  out  2*SAMP_W  reordered word {Q,I}.
REQ-014 Port o_data_valid  out  1  qualifies o_data.
REQ-015 Port o_err_hd  out  1  one-cycle pulse on truncated group.

Function
REQ-016 Write counter wcnt (clog2(2*NUM_ANT) bits) SHALL advance on each i_data_valid and wrap after 2*NUM_ANT samples.
REQ-017 Two-bank ping-pong buffer, each bank 2*NUM_ANT x SAMP_W; write bank toggles on wcnt wrap and the completed bank is flagged ready.
REQ-018 i_fram_hd SHALL force wcnt to 0 and clear the partial group; a sample valid in the same cycle is written at index 0; a pending o_fram_hd flag is set.
REQ-019 i_fram_hd with wcnt != 0 SHALL pulse o_err_hd one cycle later; the partial group produces no output.
REQ-020 On ready, reader SHALL latch i_ant_posinfo and i_ant_mask into shadow registers, then emit NUM_ANT consecutive words, slot 0..NUM_ANT-1, no gaps.
REQ-021 Slot k reads I and Q of antenna pos[k]; o_data = {Q,I}.
REQ-022 Slot k outputs zero (valid still high) if mask[k]=1 or field bits [3:POS_W] nonzero.
REQ-023 First word of a group SHALL be valid exactly 2 cycles after the cycle the group's last sample is written.
REQ-024 o_fram_hd high with slot-0 word of the first complete group after i_fram_hd, then flag clears.
REQ-025 posinfo/mask changes mid-group SHALL NOT affect the group being read.
REQ-026 All outputs registered; o_data_valid low between groups.

Reset
REQ-027 rst_491p52 high: wcnt, bank select, ready flags, reader state, frame flag cleared; all outputs 0 on the next edge.
REQ-028 Reset mid-read SHALL abort the group; no further words of it are emitted; buffer contents need not be cleared.

Configuration
REQ-029 Macro LTE_UL_REORDER_ERRCNT_EN defined: extra port o_err_cnt out 16, saturating count of o_err_hd pulses, reset 0, saturates at 0xFFFF.
REQ-030 Macro undefined: o_err_cnt port and counter absent; all other behaviour identical.

Structure
REQ-031 Shared package lte_ul_pkg holds the default NUM_ANT, SAMP_W, the 4-bit posinfo field width constant, and the 0xFFFF saturation limit.
REQ-032 Buffer is sub-module lte_ul_reorder_dpram: single clock, one write and one read port, 1-cycle read latency.

Verification
REQ-033 NUM_ANT=8, posinfo 0x76543210, mask 0, ramp i_data 0..15 -> words 0x00010000, 0x00030002 ... 0x000F000E, valid 8 cycles, o_ant_sel on first word.
REQ-034 posinfo 0x01234567, same ramp -> first word 0x000F000E, last 0x00010000.
REQ-035 mask 0x05 -> slots 0 and 2 output 0x00000000, other slots unchanged, o_data_valid high all 8 cycles.
REQ-036 i_fram_hd after 5 samples -> o_err_hd one pulse, no output for partial group, next full group's slot-0 word carries o_fram_hd; with ERRCNT_EN, o_err_cnt = 1.
REQ-037 Slot 3 field 0x8 -> slot 3 word zero; reset asserted on 3rd output word -> o_data_valid 0 from next edge, no remaining words.
